// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter.
package axi_lite_arb_pkg;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_DATA
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready,
      output araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready,
      input  araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_rr_arb2.sv
// Two-way round-robin pick; priority flips away from the owner on update.
module axi_lite_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       owner,
   output logic       gnt
);

   logic prio_q;
   logic prio_d;

   always_comb begin
      prio_d = prio_q;
      if (update) prio_d = ~owner;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end

   always_comb begin
      unique case (1'b1)
         (req == 2'b10): gnt = 1'b1;
         (req == 2'b11): gnt = prio_q;
         default:        gnt = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two AXI4-Lite masters onto one slave; write and read paths
// are arbitrated independently, one outstanding transaction each.
module axi_lite_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   axi_lite_if.slave  s0,
   axi_lite_if.slave  s1,
   axi_lite_if.master m,
   output logic       wr_grant,
   output logic       rd_grant,
   output logic       wr_busy,
   output logic       rd_busy
);

   wr_state_e wr_st_q, wr_st_d;
   logic      wr_gnt_q, wr_gnt_d;
   logic      aw_done_q, aw_done_d;
   logic      w_done_q, w_done_d;
   logic      wr_arb_gnt, wr_upd;

   rd_state_e rd_st_q, rd_st_d;
   logic      rd_gnt_q, rd_gnt_d;
   logic      rd_arb_gnt, rd_upd;

   logic [ADDR_WIDTH-1:0] awaddr_mux;
   logic [DATA_WIDTH-1:0] wdata_mux;
   logic [ADDR_WIDTH-1:0] araddr_mux;

   logic in_waddr, in_wresp, in_raddr, in_rdata;
   logic sel_awvalid, sel_wvalid, sel_bready;
   logic sel_arvalid, sel_rready;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign in_waddr = (wr_st_q == W_ADDR);
   assign in_wresp = (wr_st_q == W_RESP);
   assign in_raddr = (rd_st_q == R_ADDR);
   assign in_rdata = (rd_st_q == R_DATA);

   assign sel_awvalid = wr_gnt_q ? s1.awvalid : s0.awvalid;
   assign sel_wvalid  = wr_gnt_q ? s1.wvalid  : s0.wvalid;
   assign sel_bready  = wr_gnt_q ? s1.bready  : s0.bready;
   assign sel_arvalid = rd_gnt_q ? s1.arvalid : s0.arvalid;
   assign sel_rready  = rd_gnt_q ? s1.rready  : s0.rready;

   assign awaddr_mux = wr_gnt_q ? s1.awaddr : s0.awaddr;
   assign wdata_mux  = wr_gnt_q ? s1.wdata  : s0.wdata;
   assign araddr_mux = rd_gnt_q ? s1.araddr : s0.araddr;

   // A channel stops presenting VALID once its handshake is recorded.
   assign aw_hs = in_waddr & ~aw_done_q & sel_awvalid & m.awready;
   assign w_hs  = in_waddr & ~w_done_q & sel_wvalid & m.wready;
   assign b_hs  = in_wresp & sel_bready & m.bvalid;
   assign ar_hs = in_raddr & sel_arvalid & m.arready;
   assign r_hs  = in_rdata & sel_rready & m.rvalid;

   always_comb begin
      m.awaddr  = awaddr_mux;
      m.awvalid = in_waddr & ~aw_done_q & sel_awvalid;
      m.wdata   = wdata_mux;
      m.wvalid  = in_waddr & ~w_done_q & sel_wvalid;
      m.bready  = in_wresp & sel_bready;
      m.araddr  = araddr_mux;
      m.arvalid = in_raddr & sel_arvalid;
      m.rready  = in_rdata & sel_rready;
   end

   always_comb begin
      s0.awready = in_waddr & ~aw_done_q & ~wr_gnt_q & m.awready;
      s1.awready = in_waddr & ~aw_done_q &  wr_gnt_q & m.awready;
      s0.wready  = in_waddr & ~w_done_q & ~wr_gnt_q & m.wready;
      s1.wready  = in_waddr & ~w_done_q &  wr_gnt_q & m.wready;
      s0.bvalid  = in_wresp & ~wr_gnt_q & m.bvalid;
      s1.bvalid  = in_wresp &  wr_gnt_q & m.bvalid;
      s0.bresp   = (in_wresp & ~wr_gnt_q) ? m.bresp : RESP_OKAY;
      s1.bresp   = (in_wresp &  wr_gnt_q) ? m.bresp : RESP_OKAY;
      s0.arready = in_raddr & ~rd_gnt_q & m.arready;
      s1.arready = in_raddr &  rd_gnt_q & m.arready;
      s0.rvalid  = in_rdata & ~rd_gnt_q & m.rvalid;
      s1.rvalid  = in_rdata &  rd_gnt_q & m.rvalid;
      s0.rdata   = m.rdata;
      s1.rdata   = m.rdata;
      s0.rresp   = (in_rdata & ~rd_gnt_q) ? m.rresp : RESP_OKAY;
      s1.rresp   = (in_rdata &  rd_gnt_q) ? m.rresp : RESP_OKAY;
   end

   always_comb begin
      wr_st_d   = wr_st_q;
      wr_gnt_d  = wr_gnt_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      wr_upd    = 1'b0;
      unique case (wr_st_q)
         W_IDLE: begin
            if (s0.awvalid | s1.awvalid) begin
               wr_gnt_d = wr_arb_gnt;
               wr_st_d  = W_ADDR;
            end
         end
         W_ADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d & w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               wr_st_d   = W_RESP;
            end
         end
         W_RESP: begin
            if (b_hs) begin
               wr_upd  = 1'b1;
               wr_st_d = W_IDLE;
            end
         end
         default: wr_st_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_st_d  = rd_st_q;
      rd_gnt_d = rd_gnt_q;
      rd_upd   = 1'b0;
      unique case (rd_st_q)
         R_IDLE: begin
            if (s0.arvalid | s1.arvalid) begin
               rd_gnt_d = rd_arb_gnt;
               rd_st_d  = R_ADDR;
            end
         end
         R_ADDR: begin
            if (ar_hs) rd_st_d = R_DATA;
         end
         R_DATA: begin
            if (r_hs) begin
               rd_upd  = 1'b1;
               rd_st_d = R_IDLE;
            end
         end
         default: rd_st_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_st_q   <= W_IDLE;
         wr_gnt_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rd_st_q   <= R_IDLE;
         rd_gnt_q  <= 1'b0;
      end else begin
         wr_st_q   <= wr_st_d;
         wr_gnt_q  <= wr_gnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rd_st_q   <= rd_st_d;
         rd_gnt_q  <= rd_gnt_d;
      end
   end

   axi_lite_rr_arb2 u_wr_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({s1.awvalid, s0.awvalid}),
      .update (wr_upd),
      .owner  (wr_gnt_q),
      .gnt    (wr_arb_gnt)
   );

   axi_lite_rr_arb2 u_rd_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({s1.arvalid, s0.arvalid}),
      .update (rd_upd),
      .owner  (rd_gnt_q),
      .gnt    (rd_arb_gnt)
   );

   assign wr_grant = wr_gnt_q;
   assign rd_grant = rd_gnt_q;
   assign wr_busy  = (wr_st_q != W_IDLE);
   assign rd_busy  = (rd_st_q != R_IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench: two master drivers, a register-file slave model and monitors.
module tb_axi_lite_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s0_if ();
   axi_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s1_if ();
   axi_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

   logic wr_grant, rd_grant, wr_busy, rd_busy;

   axi_lite_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s0       (s0_if),
      .s1       (s1_if),
      .m        (m_if),
      .wr_grant (wr_grant),
      .rd_grant (rd_grant),
      .wr_busy  (wr_busy),
      .rd_busy  (rd_busy)
   );

   int total = 0;
   int bad = 0;

   logic [31:0] t_awaddr [2];
   logic [31:0] t_wdata  [2];
   logic [31:0] t_araddr [2];
   logic        t_awv [2];
   logic        t_wv  [2];
   logic        t_bready [2];
   logic        t_arv [2];
   logic        t_rready [2];

   logic awr [2];
   logic wrr [2];
   logic bv  [2];
   logic arr [2];
   logic rv  [2];

   assign s0_if.awaddr  = t_awaddr[0];
   assign s0_if.awvalid = t_awv[0];
   assign s0_if.wdata   = t_wdata[0];
   assign s0_if.wvalid  = t_wv[0];
   assign s0_if.bready  = t_bready[0];
   assign s0_if.araddr  = t_araddr[0];
   assign s0_if.arvalid = t_arv[0];
   assign s0_if.rready  = t_rready[0];
   assign s1_if.awaddr  = t_awaddr[1];
   assign s1_if.awvalid = t_awv[1];
   assign s1_if.wdata   = t_wdata[1];
   assign s1_if.wvalid  = t_wv[1];
   assign s1_if.bready  = t_bready[1];
   assign s1_if.araddr  = t_araddr[1];
   assign s1_if.arvalid = t_arv[1];
   assign s1_if.rready  = t_rready[1];

   assign awr[0] = s0_if.awready;
   assign awr[1] = s1_if.awready;
   assign wrr[0] = s0_if.wready;
   assign wrr[1] = s1_if.wready;
   assign bv[0]  = s0_if.bvalid;
   assign bv[1]  = s1_if.bvalid;
   assign arr[0] = s0_if.arready;
   assign arr[1] = s1_if.arready;
   assign rv[0]  = s0_if.rvalid;
   assign rv[1]  = s1_if.rvalid;

   // Slave model: register file, word index = low address byte.
   logic [31:0] mem [256];
   logic        aw_got, w_got, sl_bvalid, sl_rvalid;
   logic [7:0]  aw_a;
   logic [31:0] w_d, sl_rdata;
   logic [1:0]  sl_bresp;

   assign m_if.awready = !aw_got;
   assign m_if.wready  = !w_got;
   assign m_if.bvalid  = sl_bvalid;
   assign m_if.bresp   = sl_bresp;
   assign m_if.arready = !sl_rvalid;
   assign m_if.rvalid  = sl_rvalid;
   assign m_if.rdata   = sl_rdata;
   assign m_if.rresp   = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         sl_bvalid  <= 1'b0;
         sl_rvalid  <= 1'b0;
         sl_bresp   <= 2'b00;
         sl_rdata   <= 32'h0;
         aw_a       <= 8'h0;
         w_d        <= 32'h0;
         mem[8'h08] <= 32'h0808_0808;
         mem[8'h30] <= 32'h0000_CAFE;
      end else begin
         if (m_if.awvalid && !aw_got) begin
            aw_got <= 1'b1;
            aw_a   <= m_if.awaddr[7:0];
         end
         if (m_if.wvalid && !w_got) begin
            w_got <= 1'b1;
            w_d   <= m_if.wdata;
         end
         if (aw_got && w_got && !sl_bvalid) begin
            mem[aw_a] <= w_d;
            sl_bresp  <= (aw_a == 8'hF0) ? 2'b10 : 2'b00;
            sl_bvalid <= 1'b1;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
         end
         if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
         if (m_if.arvalid && !sl_rvalid) begin
            sl_rvalid <= 1'b1;
            sl_rdata  <= mem[m_if.araddr[7:0]];
         end
         if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
      end
   end

   logic [1:0]  exp_b0 [$];
   logic [1:0]  exp_b1 [$];
   logic [31:0] exp_r0 [$];
   logic [31:0] exp_r1 [$];
   logic        exp_wg [$];
   logic        exp_rg [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Response monitors: pop one expectation per handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bv[0] && t_bready[0]) begin
            if (exp_b0.size() == 0) fail("b0_extra");
            else chk("b0_resp", {30'h0, s0_if.bresp}, {30'h0, exp_b0.pop_front()});
         end
         if (bv[1] && t_bready[1]) begin
            if (exp_b1.size() == 0) fail("b1_extra");
            else chk("b1_resp", {30'h0, s1_if.bresp}, {30'h0, exp_b1.pop_front()});
         end
         if (rv[0] && t_rready[0]) begin
            if (exp_r0.size() == 0) fail("r0_extra");
            else chk("r0_data", s0_if.rdata, exp_r0.pop_front());
         end
         if (rv[1] && t_rready[1]) begin
            if (exp_r1.size() == 0) fail("r1_extra");
            else chk("r1_data", s1_if.rdata, exp_r1.pop_front());
         end
      end
   end

   logic wb_prev = 1'b0;
   logic rb_prev = 1'b0;
   always @(negedge clk) begin
      if (wr_busy && !wb_prev) begin
         if (exp_wg.size() == 0) fail("wr_grant_extra");
         else chk("wr_grant_order", {31'h0, wr_grant}, {31'h0, exp_wg.pop_front()});
      end
      if (rd_busy && !rb_prev) begin
         if (exp_rg.size() == 0) fail("rd_grant_extra");
         else chk("rd_grant_order", {31'h0, rd_grant}, {31'h0, exp_rg.pop_front()});
      end
      wb_prev = wr_busy;
      rb_prev = rd_busy;
   end

   task automatic do_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                        input int bdly, input logic [1:0] resp);
      int   n;
      logic ha, hw;
      if (i == 0) exp_b0.push_back(resp);
      else        exp_b1.push_back(resp);
      @(posedge clk); #1;
      t_awaddr[i] = a;
      t_wdata[i]  = d;
      t_awv[i]    = 1'b1;
      t_wv[i]     = 1'b1;
      n = 0;
      while ((t_awv[i] || t_wv[i]) && n < 200) begin
         @(negedge clk);
         ha = t_awv[i] && awr[i];
         hw = t_wv[i] && wrr[i];
         @(posedge clk); #1;
         if (ha) t_awv[i] = 1'b0;
         if (hw) t_wv[i] = 1'b0;
         n++;
      end
      if (t_awv[i] || t_wv[i]) begin
         fail("wr_addr_timeout");
         t_awv[i] = 1'b0;
         t_wv[i]  = 1'b0;
      end
      repeat (bdly) @(posedge clk);
      #1 t_bready[i] = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bv[i]) break;
         if (++n > 200) begin
            fail("wr_b_timeout");
            break;
         end
      end
      @(posedge clk); #1;
      t_bready[i] = 1'b0;
   endtask

   task automatic do_rd(input int i, input logic [31:0] a, input logic [31:0] d);
      int   n;
      logic h;
      if (i == 0) exp_r0.push_back(d);
      else        exp_r1.push_back(d);
      @(posedge clk); #1;
      t_araddr[i] = a;
      t_arv[i]    = 1'b1;
      t_rready[i] = 1'b1;
      n = 0;
      while (t_arv[i] && n < 200) begin
         @(negedge clk);
         h = t_arv[i] && arr[i];
         @(posedge clk); #1;
         if (h) t_arv[i] = 1'b0;
         n++;
      end
      if (t_arv[i]) begin
         fail("rd_addr_timeout");
         t_arv[i] = 1'b0;
      end
      n = 0;
      while (1) begin
         @(negedge clk);
         if (rv[i]) break;
         if (++n > 200) begin
            fail("rd_r_timeout");
            break;
         end
      end
      @(posedge clk); #1;
      t_rready[i] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=hang required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         t_awaddr[i] = '0; t_wdata[i] = '0; t_araddr[i] = '0;
         t_awv[i] = 1'b0; t_wv[i] = 1'b0; t_bready[i] = 1'b0;
         t_arv[i] = 1'b0; t_rready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_busy", {31'h0, wr_busy}, 32'h0);
      chk("rst_rd_busy", {31'h0, rd_busy}, 32'h0);
      chk("rst_wr_grant", {31'h0, wr_grant}, 32'h0);
      chk("rst_rd_grant", {31'h0, rd_grant}, 32'h0);
      chk("rst_m_valid", {29'h0, m_if.awvalid, m_if.wvalid, m_if.arvalid}, 32'h0);
      chk("rst_s_ready", {28'h0, awr[0], awr[1], arr[0], arr[1]}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Simultaneous writes to one register: master 0 first, then 1.
      exp_wg.push_back(1'b0);
      exp_wg.push_back(1'b1);
      fork
         do_wr(0, 32'h04, 32'h0000_AAAA, 0, 2'b00);
         do_wr(1, 32'h04, 32'h0000_5555, 0, 2'b00);
      join
      repeat (2) @(posedge clk);
      chk("mem_04", mem[8'h04], 32'h0000_5555);

      // Single write with grant latency check.
      exp_wg.push_back(1'b0);
      fork
         do_wr(0, 32'h10, 32'hDEAD_BEEF, 0, 2'b00);
         begin
            @(posedge clk);
            @(negedge clk);
            chk("lat_busy_early", {31'h0, wr_busy}, 32'h0);
            @(negedge clk);
            chk("lat_busy", {31'h0, wr_busy}, 32'h1);
            chk("lat_grant", {31'h0, wr_grant}, 32'h0);
         end
      join
      repeat (2) @(posedge clk);
      chk("mem_10", mem[8'h10], 32'hDEAD_BEEF);

      exp_wg.push_back(1'b1);
      do_wr(1, 32'hF0, 32'h0000_00F0, 0, 2'b10);

      for (int k = 0; k < 8; k++) exp_rg.push_back(k[0]);
      fork
         for (int k = 0; k < 4; k++) do_rd(0, 32'h08, 32'h0808_0808);
         for (int k = 0; k < 4; k++) do_rd(1, 32'h08, 32'h0808_0808);
      join

      // Write and read paths overlapping.
      exp_wg.push_back(1'b0);
      exp_rg.push_back(1'b1);
      fork
         do_wr(0, 32'h20, 32'h0000_1234, 0, 2'b00);
         do_rd(1, 32'h30, 32'h0000_CAFE);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(wr_busy && rd_busy) && n < 50);
            chk("overlap_busy", {30'h0, wr_busy, rd_busy}, 32'h3);
         end
      join
      repeat (2) @(posedge clk);
      chk("mem_20", mem[8'h20], 32'h0000_1234);

      // B backpressure on master 0 while master 1 waits on AW.
      exp_wg.push_back(1'b0);
      exp_wg.push_back(1'b1);
      fork
         do_wr(0, 32'h50, 32'h0000_0011, 5, 2'b00);
         begin
            repeat (3) @(posedge clk);
            do_wr(1, 32'h54, 32'h0000_0022, 0, 2'b00);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!bv[0] && n < 50);
            chk("bp_seen", {31'h0, bv[0]}, 32'h1);
            repeat (3) begin
               @(negedge clk);
               chk("bp_bvalid_held", {31'h0, bv[0]}, 32'h1);
               chk("bp_s1_aw_wait", {30'h0, t_awv[1], awr[1]}, 32'h2);
               chk("bp_grant", {30'h0, wr_busy, wr_grant}, 32'h2);
            end
         end
      join
      repeat (2) @(posedge clk);
      chk("mem_54", mem[8'h54], 32'h0000_0022);

      exp_wg.push_back(1'b0);
      do_wr(0, 32'h40, 32'h0000_0077, 0, 2'b00);

      // Reset after AW is accepted but before W.
      exp_wg.push_back(1'b0);
      @(posedge clk); #1;
      t_awaddr[0] = 32'h60;
      t_awv[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!awr[0] && n < 50);
      chk("rst_aw_accept", {31'h0, awr[0]}, 32'h1);
      @(posedge clk); #1 t_awv[0] = 1'b0;
      @(negedge clk);
      chk("mid_busy", {31'h0, wr_busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'h0, wr_busy}, 32'h0);
      chk("mid_rst_out", {28'h0, m_if.awvalid, m_if.wvalid, wrr[0], bv[0]}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst", {30'h0, wr_busy, wr_grant}, 32'h0);
      exp_wg.push_back(1'b0);
      exp_wg.push_back(1'b1);
      fork
         do_wr(0, 32'h64, 32'h0000_0100, 0, 2'b00);
         do_wr(1, 32'h64, 32'h0000_0200, 0, 2'b00);
      join
      repeat (3) @(posedge clk);
      chk("mem_64", mem[8'h64], 32'h0000_0200);

      chk("left_b0", exp_b0.size(), 32'h0);
      chk("left_b1", exp_b1.size(), 32'h0);
      chk("left_r0", exp_r0.size(), 32'h0);
      chk("left_r1", exp_r1.size(), 32'h0);
      chk("left_wg", exp_wg.size(), 32'h0);
      chk("left_rg", exp_rg.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
